// File: rtl/rv32i_types.sv
// Shared RV32I types used across the fetch and resolve stages.
// Holds the machine word type and the BTB update opcode.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic {
        BTB_ALLOC = 1'b0,
        BTB_INVAL = 1'b1
    } btb_op_t;

endpackage

// File: rtl/btb_plru.sv
// Tree pseudo-LRU helper: next-tree on access and current victim way.
// Node n has children 2n+1 / 2n+2; a bit of 1 points the victim to the right.
module btb_plru #(
    parameter  int WAYS = 2,
    localparam int TW   = (WAYS > 1) ? WAYS - 1 : 1,
    localparam int LW   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic [TW-1:0] tree_i,
    input  logic [LW-1:0] acc_way_i,
    output logic [TW-1:0] tree_o,
    output logic [LW-1:0] victim_o
);

    if (WAYS == 1) begin : g_single
        logic unused_in;
        assign unused_in = ^{tree_i, acc_way_i};
        assign tree_o    = '0;
        assign victim_o  = '0;
    end else begin : g_tree
        logic [WAYS-1:0] vmatch;

        // Nodes on the accessed path point away from the accessed way.
        for (genvar n = 0; n < TW; n++) begin : g_node
            localparam int LV = $clog2(n + 2) - 1;
            localparam int P  = n + 1 - (1 << LV);
            assign tree_o[n] = (int'(acc_way_i >> (LW - LV)) == P)
                             ? ~acc_way_i[LW-1-LV] : tree_i[n];
        end

        // A way is the victim when every node on its path points at it.
        for (genvar w = 0; w < WAYS; w++) begin : g_way
            logic [LW-1:0] ok;
            for (genvar l = 0; l < LW; l++) begin : g_lvl
                localparam int       ND = (1 << l) - 1 + (w >> (LW - l));
                localparam bit [0:0] B  = 1'((w >> (LW - 1 - l)) & 1);
                assign ok[l] = (tree_i[ND] == B);
            end
            assign vmatch[w] = &ok;
        end

        // Encode the single matching way.
        always_comb begin
            victim_o = '0;
            for (int w = 0; w < WAYS; w++) begin
                if (vmatch[w]) victim_o = LW'(w);
            end
        end
    end

endmodule

// File: rtl/btb_set_assoc.sv
// Set-associative partially tagged BTB with tree-PLRU replacement.
// Registered lookup; resolve-stage allocate/invalidate; global flush.
module btb_set_assoc
    import rv32i_types::*;
#(
    parameter int S_INDEX = 6,
    parameter int WAYS    = 2,
    parameter int TAG_W   = 12
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      predict_en,
    input  rv32i_word curr_pc,
    output logic      pred_valid,
    output logic      pred_hit,
    output rv32i_word pred_target,
    input  logic      update_en,
    input  btb_op_t   update_op,
    input  rv32i_word resolved_pc,
    input  rv32i_word expected_next_pc,
    input  logic      flush
);

    localparam int NUM_SETS = 2 ** S_INDEX;
    localparam int TW = (WAYS > 1) ? WAYS - 1 : 1;
    localparam int LW = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [WAYS-1:0]  valid_q [NUM_SETS];
    logic [TAG_W-1:0] tag_q   [NUM_SETS][WAYS];
    rv32i_word        tgt_q   [NUM_SETS][WAYS];
    logic [TW-1:0]    plru_q  [NUM_SETS];

    logic      pred_valid_q, pred_hit_q;
    rv32i_word pred_target_q;

    logic [S_INDEX-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0]   lk_tag, up_tag;
    logic [WAYS-1:0]    lk_match, up_match;
    rv32i_word          lk_tgt;
    logic               up_hit, inv_any;
    logic [LW-1:0]      up_hway, inv_way, vic_way, wr_way;
    logic [TW-1:0]      plru_nxt;
    logic               unused_pc;

    assign lk_idx    = curr_pc[2 +: S_INDEX];
    assign lk_tag    = curr_pc[2+S_INDEX +: TAG_W];
    assign up_idx    = resolved_pc[2 +: S_INDEX];
    assign up_tag    = resolved_pc[2+S_INDEX +: TAG_W];
    assign unused_pc = ^{curr_pc, resolved_pc};

    // Tag compare for both the fetch lookup and the resolve update.
    always_comb begin
        lk_tgt  = '0;
        up_hway = '0;
        inv_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            lk_match[w] = valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag);
            up_match[w] = valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag);
            if (lk_match[w]) lk_tgt = lk_tgt | tgt_q[lk_idx][w];
            if (up_match[w]) up_hway = LW'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[up_idx][w]) inv_way = LW'(w);
        end
    end

    assign up_hit  = |up_match;
    assign inv_any = ~&valid_q[up_idx];
    assign wr_way  = up_hit ? up_hway : (inv_any ? inv_way : vic_way);

    btb_plru #(.WAYS(WAYS)) u_plru (
        .tree_i    (plru_q[up_idx]),
        .acc_way_i (wr_way),
        .tree_o    (plru_nxt),
        .victim_o  (vic_way)
    );

    // Registered prediction; hit/target hold while no lookup is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pred_valid_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_target_q <= '0;
        end else begin
            pred_valid_q <= predict_en;
            if (predict_en) begin
                pred_hit_q    <= |lk_match;
                pred_target_q <= lk_tgt;
            end
        end
    end

    // Valid bits and PLRU trees; flush wins over any update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else if (flush) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else if (update_en) begin
            unique case (update_op)
                BTB_ALLOC: begin
                    valid_q[up_idx][wr_way] <= 1'b1;
                    plru_q[up_idx]          <= plru_nxt;
                end
                BTB_INVAL: begin
                    if (up_hit) valid_q[up_idx][up_hway] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Tag and target payload, written on allocate only.
    always_ff @(posedge clk) begin
        if (update_en && !flush && update_op == BTB_ALLOC) begin
            tag_q[up_idx][wr_way] <= up_tag;
            tgt_q[up_idx][wr_way] <= expected_next_pc;
        end
    end

    assign pred_valid  = pred_valid_q;
    assign pred_hit    = pred_hit_q;
    assign pred_target = pred_target_q;

    a_lk_onehot: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(lk_match));
    a_up_onehot: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(up_match));

endmodule

// File: doc/btb_set_assoc.md
# btb_set_assoc

Set-associative, partially tagged branch target buffer for the fetch stage. It is the successor to the direct-mapped untagged target table, with these additions:
- WAYS-way associativity with tree-PLRU replacement;
- tag/valid qualification, so a prediction is only made on a genuine hit;
- a registered (1-cycle) lookup;
- explicit allocate/invalidate update operations from the resolve stage, and a global flush.

Fetch issues lookups on curr_pc; the resolve stage writes back outcomes.

## Interface
- S_INDEX, 6: index bits; NUM_SETS = 2**S_INDEX; index = pc[2 +: S_INDEX].
- WAYS, 2: associativity; legal values 1, 2, 4, 8.
- TAG_W, 12: partial tag width; tag = pc[2+S_INDEX +: TAG_W]; 2+S_INDEX+TAG_W ≤ 32 required.

Ports (clock and reset first):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset; low clears all state immediately.
- predict_en  in  1  lookup strobe; high captures curr_pc this edge.
- curr_pc  in  32  fetch PC (rv32i_word).
- pred_valid  out  1  registered: a lookup completed last enabled edge.
- pred_hit  out  1  registered hit flag for that lookup.
- pred_target  out  32  registered target; 0 on miss.
- update_en  in  1  resolve-stage write strobe.
- update_op  in  btb_op_t  BTB_ALLOC (install/refresh target) or BTB_INVAL (remove entry).
- resolved_pc  in  32  PC of the resolved control-flow instruction.
- expected_next_pc  in  32  correct target for BTB_ALLOC.
- flush  in  1  synchronous invalidate-all.

## Operation
- Per set, per way: valid bit, TAG_W tag, 32-bit target.
- Per set: (WAYS-1)-bit PLRU tree. For WAYS=1 the tree is absent and the victim is always way 0.

Lookup:
- Compare the tag against all valid ways of set[curr_index].
- Hit:
  - pred_hit = 1 and pred_target = that way's target.
  - More than one way matching is impossible by construction; an assertion enforces it.
- Miss: pred_hit = 0 and pred_target = 0.
- Lookups do not touch PLRU.

BTB_ALLOC:
- Hit in set[resolved_index]: overwrite that way's target and mark the way MRU in PLRU.
- Miss: choose a victim and write valid=1, tag, and target; mark the victim MRU.
  - Victim is the lowest-index invalid way if one exists.
  - Otherwise the victim is the PLRU victim.

BTB_INVAL:
- Hit: clear that way's valid bit; PLRU unchanged.
- Miss: no-op.

flush: clears every valid bit and every PLRU tree at the next edge. Tags and targets are don't-care.

Priority: flush over update. When both are high, the update is dropped.

## Timing
Reset (rst low, asynchronous):
- pred_valid = 0, pred_hit = 0, pred_target = 0.
- All valid bits = 0 and all PLRU = 0.
- Deassertion takes effect at the next rising edge.

Lookup latency:
- curr_pc is sampled at edge N when predict_en = 1; results are visible after edge N.
- pred_valid = 1 for exactly that cycle unless predict_en is held high.
- When predict_en = 0, pred_valid = 0 at the next edge and pred_hit/pred_target hold their last value.

Update latency: the write is visible to lookups sampled at edge N+1 or later.

Same-edge update and lookup to the same set (including the same PC): the lookup returns pre-update contents (read-old). No bypass.

Same-edge flush and lookup: the lookup returns pre-flush contents. A lookup at the following edge misses.

Back-to-back updates to the same set on consecutive cycles must each see the previous update's PLRU state.

Mid-operation reset drops any in-flight lookup result, with no residual pred_valid.

## Structure
- Add btb_op_t (BTB_ALLOC, BTB_INVAL) to the shared rv32i_types package, alongside rv32i_word.
- One sub-module, btb_plru, parametrised by WAYS:
  - inputs: current tree bits and accessed way; output: updated tree;
  - input: tree bits; output: victim way;
  - purely combinational.
- Storage is flip-flop arrays with asynchronous reset of valid and PLRU only. Tag and target arrays are unreset.

## Test plan
1. Reset, then lookup at 0x0000_0100 → pred_valid = 1 and pred_hit = 0 the cycle after the edge; pred_target = 0.
2. BTB_ALLOC at 0x0000_0100 with target 0x0000_0400; lookup next cycle → hit, target 0x0000_0400. Lookup at 0x0001_0100 (same index, different tag) → miss.
3. WAYS=2, S_INDEX=6: ALLOC at 0x100→A, 0x1100→B, then a re-ALLOC refresh of 0x100 (marks it MRU); ALLOC 0x2100→C. Result: B is evicted; lookups of 0x100 and 0x2100 hit, 0x1100 misses.
4. Same-edge update and lookup: ALLOC at 0x200→0x800 with a lookup of 0x200 on the same edge → miss. Repeating the lookup next cycle → hit 0x800.
5. BTB_INVAL at 0x100 after an allocate → the next lookup misses. A subsequent ALLOC at 0x1100 reuses the freed way (lowest invalid) without evicting a valid way.
6. Fill 4 sets, then assert flush together with an update_en ALLOC → all subsequent lookups miss, including the flushed-over ALLOC. Pulse rst low mid-lookup → pred_valid drops to 0 asynchronously.
